// File: rtl/dbg_pkg.sv
// Debug bus address layout, AXI response codes and bridge FSM states.
package dbg;
  localparam int Seg_w  = 4;
  localparam int Off_w  = 8;
  localparam int Addr_w = Seg_w + Off_w;

  typedef struct packed {
    logic [Seg_w-1:0] seg;
    logic [Off_w-1:0] addr;
  } addr_t;

  localparam logic [1:0] Resp_okay   = 2'b00;
  localparam logic [1:0] Resp_decerr = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WRESP,
    RD,
    RWAIT,
    RRESP
  } br_state_t;
endpackage

// File: rtl/mcs4_pkg.sv
// Byte type shared by the debug bus and its clients.
package mcs4;
  typedef logic [7:0] byte_t;
endpackage

// File: rtl/dbg_axil_bridge.sv
// AXI4-Lite slave to byte-wide debug bus, one transaction outstanding; write 3 / read READ_LAT+2 cycles,
// B/R held until accepted. DBG_AXIL_DECERR_EN: out-of-range addresses answer DECERR without a strobe.
module dbg_axil_bridge
  import dbg::*;
#(
  parameter int AXIL_AW  = 16,
  parameter int READ_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AXIL_AW-1:0] s_awaddr,
  input  logic               s_awvalid,
  output logic               s_awready,
  input  logic [31:0]        s_wdata,
  input  logic [3:0]         s_wstrb,
  input  logic               s_wvalid,
  output logic               s_wready,
  output logic [1:0]         s_bresp,
  output logic               s_bvalid,
  input  logic               s_bready,
  input  logic [AXIL_AW-1:0] s_araddr,
  input  logic               s_arvalid,
  output logic               s_arready,
  output logic [31:0]        s_rdata,
  output logic [1:0]         s_rresp,
  output logic               s_rvalid,
  input  logic               s_rready,
  output addr_t              dbg_addr,
  output logic               dbg_wen,
  output logic               dbg_ren,
  output mcs4::byte_t        dbg_wdata,
  input  mcs4::byte_t        dbg_rdata
);

  localparam int Cnt_w = (READ_LAT > 2) ? $clog2(READ_LAT - 1) : 1;

  br_state_t        state_q, state_d;
  logic [Cnt_w-1:0] cnt_q, cnt_d;
  logic             prio_wr_q;
  logic             wen_arm_q, ren_arm_q;
  logic             wr_req, wr_go, rd_go, contend, cap;
  logic             aw_bad, ar_bad;
  logic             unused_bits;

  assign wr_req      = s_awvalid && s_wvalid;
  assign unused_bits = ^{s_awaddr, s_araddr, s_wdata, s_wstrb};

`ifdef DBG_AXIL_DECERR_EN
  assign aw_bad = (s_awaddr >> (Addr_w + 2)) != '0;
  assign ar_bad = (s_araddr >> (Addr_w + 2)) != '0;
`else
  assign aw_bad = 1'b0;
  assign ar_bad = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_arready = 1'b0;
    wr_go     = 1'b0;
    rd_go     = 1'b0;
    contend   = 1'b0;
    cap       = 1'b0;
    unique case (state_q)
      IDLE: begin
        contend   = wr_req && s_arvalid;
        wr_go     = wr_req && (prio_wr_q || !s_arvalid);
        rd_go     = s_arvalid && !wr_go;
        s_awready = wr_go;
        s_wready  = wr_go;
        s_arready = rd_go;
        if (wr_go) begin
          state_d = WR;
        end else if (rd_go) begin
          state_d = RD;
        end
      end
      WR:    state_d = WRESP;
      WRESP: if (s_bready) state_d = IDLE;
      RD: begin
        if (READ_LAT <= 1) begin
          cap     = 1'b1;
          state_d = RRESP;
        end else begin
          cnt_d   = Cnt_w'(READ_LAT - 2);
          state_d = RWAIT;
        end
      end
      RWAIT: begin
        // Last wait cycle is exactly READ_LAT edges after the strobe went out.
        if (cnt_q == '0) begin
          cap     = 1'b1;
          state_d = RRESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RRESP:   if (s_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prio_wr_q <= 1'b1;
      wen_arm_q <= 1'b0;
      ren_arm_q <= 1'b0;
      dbg_addr  <= '0;
      dbg_wdata <= '0;
      s_bresp   <= Resp_okay;
      s_rresp   <= Resp_okay;
      s_rdata   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (contend) prio_wr_q <= !wr_go;
      if (wr_go) begin
        dbg_addr  <= addr_t'(s_awaddr[Addr_w+1:2]);
        dbg_wdata <= s_wdata[7:0];
        wen_arm_q <= s_wstrb[0] && !aw_bad;
        s_bresp   <= aw_bad ? Resp_decerr : Resp_okay;
      end
      if (rd_go) begin
        dbg_addr  <= addr_t'(s_araddr[Addr_w+1:2]);
        ren_arm_q <= !ar_bad;
        s_rresp   <= ar_bad ? Resp_decerr : Resp_okay;
      end
      if (cap) s_rdata <= ren_arm_q ? {24'h0, dbg_rdata} : '0;
    end
  end

  assign dbg_wen  = (state_q == WR) && wen_arm_q;
  assign dbg_ren  = (state_q == RD) && ren_arm_q;
  assign s_bvalid = (state_q == WRESP);
  assign s_rvalid = (state_q == RRESP);

endmodule

// File: tb/tb_dbg_axil_bridge.sv
// Randomized AXI4-Lite traffic against a byte-array model of the debug space, plus directed corner cases.
module tb_dbg_axil_bridge;
  import dbg::*;

  localparam int READ_LAT = 2;
  localparam int AW       = 16;
  localparam int NWORDS   = 1 << Addr_w;
`ifdef DBG_AXIL_DECERR_EN
  localparam bit DECERR_EN = 1'b1;
`else
  localparam bit DECERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic          s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic          s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0]   s_wdata, s_rdata;
  logic [3:0]    s_wstrb;
  logic [1:0]    s_bresp, s_rresp;
  addr_t         dbg_addr;
  logic          dbg_wen, dbg_ren;
  mcs4::byte_t   dbg_wdata, dbg_rdata;

  always #5 clk = ~clk;

  dbg_axil_bridge #(.AXIL_AW(AW), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .dbg_addr(dbg_addr), .dbg_wen(dbg_wen), .dbg_ren(dbg_ren),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic mcs4::byte_t init_byte(input int i);
    return 8'(i * 7 + 46);
  endfunction

  // Debug-space device: answers a read with data valid only on the capture cycle.
  mcs4::byte_t dev_mem [NWORDS];
  logic        mem_init = 1'b0;
  logic [Addr_w-1:0] dbg_addr_flat, rd_addr, last_waddr, last_raddr;
  mcs4::byte_t last_wdata;
  int          rd_cd = 0;
  int          wen_cnt = 0, ren_cnt = 0, both_viol = 0, order_n = 0;
  logic        order_log [16];

  assign dbg_addr_flat = dbg_addr;
  assign dbg_rdata     = (rd_cd == 1) ? dev_mem[rd_addr] : ~dev_mem[rd_addr];

  always @(posedge clk) begin
    if (rst && !mem_init) begin
      for (int i = 0; i < NWORDS; i++) dev_mem[i] <= init_byte(i);
      mem_init <= 1'b1;
    end
    if (dbg_wen) begin
      dev_mem[dbg_addr_flat] <= dbg_wdata;
      wen_cnt    <= wen_cnt + 1;
      last_waddr <= dbg_addr_flat;
      last_wdata <= dbg_wdata;
      if (order_n < 16) begin
        order_log[order_n] <= 1'b1;
        order_n <= order_n + 1;
      end
    end
    if (dbg_ren) begin
      ren_cnt    <= ren_cnt + 1;
      last_raddr <= dbg_addr_flat;
      rd_addr    <= dbg_addr_flat;
      rd_cd      <= READ_LAT - 1;
      if (order_n < 16) begin
        order_log[order_n] <= 1'b0;
        order_n <= order_n + 1;
      end
    end else if (rd_cd > 0) begin
      rd_cd <= rd_cd - 1;
    end
    if (dbg_wen && dbg_ren) both_viol <= both_viol + 1;
  end

  // Reference model: the debug space as the AXI master should see it.
  mcs4::byte_t ref_mem [NWORDS];

  function automatic logic is_bad(input logic [AW-1:0] a);
    return DECERR_EN && ((int'(a) >> (Addr_w + 2)) != 0);
  endfunction

  function automatic int widx(input logic [AW-1:0] a);
    return (int'(a) >> 2) % NWORDS;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    int idx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, NWORDS - 1);
    int up  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    return AW'((up << (Addr_w + 2)) | (idx << 2) | $urandom_range(0, 3));
  endfunction

  task automatic axil_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] st,
                            input int bdly, output logic [1:0] resp);
    int   n = 0;
    logic hs = 1'b0;
    s_awaddr = a; s_wdata = d; s_wstrb = st; s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
    while (!hs && n < 100) begin
      @(negedge clk);
      n++;
      check("aw_w_pair", s_awready, s_wready);
      hs = s_awready && s_wready;
      @(posedge clk); #1;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check("aw_accept", hs, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!s_bvalid && n < 100);
    check("b_latency", n, 2);
    resp = s_bresp;
    for (int i = 0; i < bdly; i++) begin
      @(negedge clk);
      check("b_hold", {s_bvalid, s_bresp}, {1'b1, resp});
    end
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
  endtask

  task automatic axil_read(input logic [AW-1:0] a, input int rdly,
                           output logic [1:0] resp, output logic [31:0] data);
    int   n = 0;
    int   r0;
    logic hs = 1'b0;
    s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b0;
    while (!hs && n < 100) begin
      @(negedge clk);
      n++;
      hs = s_arready;
      @(posedge clk); #1;
    end
    s_arvalid = 1'b0;
    check("ar_accept", hs, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!s_rvalid && n < 100);
    check("r_latency", n, READ_LAT + 1);
    resp = s_rresp; data = s_rdata; r0 = ren_cnt;
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      check("r_hold_vld", {s_rvalid, s_rresp}, {1'b1, resp});
      check("r_hold_dat", s_rdata, data);
      check("r_no_new_ren", ren_cnt - r0, 0);
    end
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] st, input int bdly);
    logic [1:0] resp;
    int   w0 = wen_cnt;
    logic bad = is_bad(a);
    logic strobe = st[0] && !bad;
    axil_write(a, d, st, bdly, resp);
    check("bresp", resp, bad ? 2'b11 : 2'b00);
    check("wen_pulses", wen_cnt - w0, strobe);
    if (strobe) begin
      check("wen_addr", last_waddr, widx(a));
      check("wen_data", last_wdata, d[7:0]);
      ref_mem[widx(a)] = d[7:0];
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int rdly);
    logic [1:0]  resp;
    logic [31:0] data;
    int   r0 = ren_cnt;
    logic bad = is_bad(a);
    axil_read(a, rdly, resp, data);
    check("rresp", resp, bad ? 2'b11 : 2'b00);
    check("rdata", data, bad ? 32'h0 : {24'h0, ref_mem[widx(a)]});
    check("ren_pulses", ren_cnt - r0, bad ? 0 : 1);
    if (!bad) check("ren_addr", last_raddr, widx(a));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hs"}, {s_awready, s_wready, s_arready, s_bvalid, s_rvalid}, 0);
    check({tag, "_strobe"}, {dbg_wen, dbg_ren}, 0);
    check({tag, "_addr"}, dbg_addr, 0);
    check({tag, "_wdata"}, dbg_wdata, 0);
    check({tag, "_rdata"}, s_rdata, 0);
    check({tag, "_resp"}, {s_bresp, s_rresp}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

  initial begin
    int base, r0, w0, hs_n;
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = init_byte(i);
    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Contending write/read pairs right after reset: write wins first, then alternation.
    base = order_n;
    fork
      begin
        do_write(16'h0100, 32'h0000_00A1, 4'h1, 0);
        do_write(16'h0104, 32'h0000_00A2, 4'h1, 0);
      end
      begin
        do_read(16'h0200, 0);
        do_read(16'h0204, 0);
      end
    join
    check("arb_count", order_n - base, 4);
    for (int i = 0; i < 4; i++) check("arb_order", order_log[base + i], (i % 2) == 0);

    do_write(16'h0004, 32'h0000_005A, 4'h1, 0);
    do_read(16'h0008, 0);
    do_write(16'h000C, 32'h0000_0077, 4'h2, 1);
    do_read(16'h000C, 0);
    do_read(16'h0004, 5);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
      else
        do_read(rand_addr(), $urandom_range(0, 3));
    end

    do_read(16'h8000, 0);

    // Reset while the read is waiting for debug data.
    s_araddr = 16'h0010; s_arvalid = 1'b1;
    hs_n = 0;
    do begin @(negedge clk); hs_n++; end while (!s_arready && hs_n < 100);
    check("rst_ar_accept", s_arready, 1);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    r0 = ren_cnt; w0 = wen_cnt;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_strobe", (ren_cnt - r0) + (wen_cnt - w0), 0);
    check("midrst_no_resp", {s_rvalid, s_bvalid}, 0);

    do_read(16'h0010, 0);
    check("strobe_excl", both_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dbg_axil_bridge.md
DBG_AXIL_BRIDGE -- requirements
Module: dbg_axil_bridge

Interface
REQ-001 Parameter AXIL_AW, default 16, AXI4-Lite address width in bits (>= dbg::Addr_w+2).
REQ-002 Parameter READ_LAT, default 2, cycles from dbg_ren assertion to valid dbg_rdata.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_awaddr/s_awvalid/s_awready  in/in/out  AXIL_AW/1/1  write address channel.
REQ-006 s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  32/4/1/1  write data channel.
REQ-007 s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  write response channel.
REQ-008 s_araddr/s_arvalid/s_arready  in/in/out  AXIL_AW/1/1  read address channel.
REQ-009 s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  32/2/1/1  read data channel.
REQ-010 dbg_addr  output  dbg::addr_t  debug bus address {seg, addr}.
REQ-011 dbg_wen, dbg_ren  output  1 each  single-cycle write/read strobes.
REQ-012 dbg_wdata  output  mcs4::byte_t  write byte.
REQ-013 dbg_rdata  input  mcs4::byte_t  read byte, valid READ_LAT cycles after dbg_ren.

Function
REQ-014 Address map: dbg_addr = axaddr[dbg::Addr_w+1:2]; one debug byte per 32-bit word; axaddr[1:0] ignored.
REQ-015 FSM states IDLE, WR, WRESP, RD, RWAIT, RRESP.
REQ-016 IDLE: s_awready=s_wready=1 only when s_awvalid&&s_wvalid both high; AW and W accepted in the same cycle, never separately.
REQ-017 IDLE: s_arready=1 when s_arvalid high and no write is selected.
REQ-018 Simultaneous write and read pending in IDLE: grant alternates, starting with write after reset; the ungranted request waits.
REQ-019 Accept write -> WR: dbg_addr, dbg_wdata=s_wdata[7:0] registered; dbg_wen=1 for exactly one cycle in WR only if s_wstrb[0]=1, else no strobe.
REQ-020 WR -> WRESP: s_bvalid=1, s_bresp=OKAY, held until s_bready; then IDLE.
REQ-021 Accept read -> RD: dbg_addr registered; dbg_ren=1 for exactly one cycle in RD.
REQ-022 RD -> RWAIT: counter counts READ_LAT-1 further cycles; dbg_rdata captured on the cycle READ_LAT after dbg_ren.
REQ-023 RWAIT -> RRESP: s_rdata={24'h0, captured byte}, s_rresp=OKAY, s_rvalid held until s_rready; then IDLE.
REQ-024 dbg_addr holds its last value outside transactions and stays stable from strobe through capture.
REQ-025 dbg_wen and dbg_ren are never both high; at most one transaction is outstanding.
REQ-026 s_bvalid/s_rvalid, once asserted, stay asserted with stable payload until accepted.
REQ-027 Minimum throughput: write 3 cycles, read READ_LAT+2 cycles, with bready/rready held high.

Reset
REQ-028 On rst: state IDLE; all ready/valid outputs 0; dbg_wen=dbg_ren=0; dbg_addr=0; dbg_wdata=0; s_rdata=0; s_bresp=s_rresp=0; arbitration favours write.
REQ-029 rst mid-transaction abandons it with no response; no dbg strobe in the cycle following rst.

Configuration
REQ-030 Macro DBG_AXIL_DECERR_EN defined: any nonzero axaddr bit above dbg::Addr_w+1 gives DECERR (2'b11), no dbg strobe, s_rdata=0, same response timing.
REQ-031 Macro undefined: upper address bits ignored (aliasing); responses are always OKAY.

Structure
REQ-032 dbg package holds Addr_w, addr_t, and the AXI response constants Resp_okay=2'b00 and Resp_decerr=2'b11.
REQ-033 Single flat module, no sub-modules.

Verification
REQ-034 Write awaddr=0x0004, wdata=0x5A, wstrb=0x1 -> one dbg_wen cycle, dbg_addr=1, dbg_wdata=0x5A, bresp OKAY.
REQ-035 Read araddr=0x0008 with dbg_rdata=0x3C driven 2 cycles after dbg_ren -> rdata=0x0000003C, rresp OKAY.
REQ-036 Write with wstrb=0x2 -> no dbg_wen, bresp OKAY.
REQ-037 AW+W and AR asserted together twice in a row -> order is write, read, write, read.
REQ-038 rready low for 5 cycles -> rvalid and rdata stable for all 5 cycles; no new dbg_ren issued.
REQ-039 With DBG_AXIL_DECERR_EN defined, read araddr=0x8000 (bit beyond range) -> rresp=2'b11, no dbg_ren; rst asserted during RWAIT -> outputs reach their reset values on the next cycle.
